// File: rtl/issue_lsu.sv
// issue_lsu: single-entry load/store unit between the issue queue, data memory and the CDB
// Ports:
//   clk, reset                     : clock, asynchronous active-low reset
//   issuels_* (in), issuels_done   : head of the load/store queue and its acceptance strobe
//   dmem_req/we/addr/wdata, dmem_ack/rdata : data memory request and completion
//   cdb_req/tag/data, cdb_grant    : load-result broadcast and arbiter grant
//   ls_misalign, ls_misalign_addr  : one-cycle trap on a misaligned access
//   ls_nload, ls_nstore            : wrapping counters of completed loads and stores
module issue_lsu #(
    parameter bit ALIGN_CHECK = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        issuels_opcode,
    input  logic [5:0]  issuels_rttag,
    input  logic [31:0] issuels_addr,
    input  logic [31:0] issuels_data,
    input  logic        issuels_ready,
    output logic        issuels_done,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        cdb_req,
    output logic [5:0]  cdb_tag,
    output logic [31:0] cdb_data,
    input  logic        cdb_grant,
    output logic        ls_misalign,
    output logic [31:0] ls_misalign_addr,
    output logic [15:0] ls_nload,
    output logic [15:0] ls_nstore
);
    typedef enum logic [1:0] {IDLE, MEM, CDB} state_t;
    state_t      state;
    logic        op_q;
    logic [5:0]  tag_q;
    logic [31:0] addr_q;
    logic [31:0] data_q;
    logic        misaligned;
    // Request outputs are decoded straight from the state register so the
    // asynchronous reset clears them immediately, without waiting for an edge.
    always_comb begin
        issuels_done = issuels_ready && state == IDLE;
        misaligned   = ALIGN_CHECK && issuels_addr[1:0] != 2'b00;
        dmem_req     = state == MEM;
        dmem_we      = dmem_req && op_q;
        dmem_addr    = dmem_req ? addr_q : '0;
        dmem_wdata   = dmem_req ? data_q : '0;
        cdb_req      = state == CDB;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state            <= IDLE;
            op_q             <= 1'b0;
            tag_q            <= '0;
            addr_q           <= '0;
            data_q           <= '0;
            cdb_tag          <= '0;
            cdb_data         <= '0;
            ls_misalign      <= 1'b0;
            ls_misalign_addr <= '0;
            ls_nload         <= '0;
            ls_nstore        <= '0;
        end else begin
            ls_misalign <= 1'b0;
            case (state)
                IDLE: if (issuels_done) begin
                    op_q   <= issuels_opcode;
                    tag_q  <= issuels_rttag;
                    addr_q <= issuels_addr;
                    data_q <= issuels_data;
                    // A trapped access is consumed from the queue but never reaches memory.
                    if (misaligned) begin
                        ls_misalign      <= 1'b1;
                        ls_misalign_addr <= issuels_addr;
                    end else begin
                        state <= MEM;
                    end
                end
                MEM: if (dmem_ack) begin
                    if (op_q) begin
                        ls_nstore <= ls_nstore + 16'd1;
                        state     <= IDLE;
                    end else begin
                        cdb_tag  <= tag_q;
                        cdb_data <= dmem_rdata;
                        state    <= CDB;
                    end
                end
                CDB: if (cdb_grant) begin
                    ls_nload <= ls_nload + 16'd1;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_issue_lsu.sv
// tb_issue_lsu: scoreboard bench for issue_lsu with directed load/store/trap/reset/wrap vectors
module tb_issue_lsu;
    logic        clk;
    logic        reset;
    logic        issuels_opcode;
    logic [5:0]  issuels_rttag;
    logic [31:0] issuels_addr;
    logic [31:0] issuels_data;
    logic        issuels_ready;
    logic        issuels_done;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        cdb_req;
    logic [5:0]  cdb_tag;
    logic [31:0] cdb_data;
    logic        cdb_grant;
    logic        ls_misalign;
    logic [31:0] ls_misalign_addr;
    logic [15:0] ls_nload;
    logic [15:0] ls_nstore;

    issue_lsu #(.ALIGN_CHECK(1'b1)) dut (
        .clk(clk), .reset(reset),
        .issuels_opcode(issuels_opcode), .issuels_rttag(issuels_rttag),
        .issuels_addr(issuels_addr), .issuels_data(issuels_data),
        .issuels_ready(issuels_ready), .issuels_done(issuels_done),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .cdb_req(cdb_req), .cdb_tag(cdb_tag), .cdb_data(cdb_data), .cdb_grant(cdb_grant),
        .ls_misalign(ls_misalign), .ls_misalign_addr(ls_misalign_addr),
        .ls_nload(ls_nload), .ls_nstore(ls_nstore)
    );

    localparam int K_MEM = 0;
    localparam int K_CDB = 1;
    localparam int K_MIS = 2;

    typedef struct {
        int          kind;
        logic        we;
        logic [5:0]  tag;
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    exp_t        sbq[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          mem_wait = 0;
    int          cdb_wait = 0;
    int          dreq_cyc = 0;
    int          creq_cyc = 0;
    int          done_cyc = 0;
    logic [15:0] exp_nld = '0;
    logic [15:0] exp_nst = '0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: got no completion, expected summary before timeout");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Memory contents seen by loads.
    function automatic logic [31:0] rd_of(input logic [31:0] a);
        return a == 32'h40 ? 32'h1234_5678 : ~a ^ 32'h0F0F_0000;
    endfunction

    // Memory and CDB responders with programmable wait cycles.
    initial begin
        int mcnt, ccnt;
        mcnt = 0;
        ccnt = 0;
        dmem_ack = 1'b0;
        cdb_grant = 1'b0;
        dmem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            dmem_ack   = reset && dmem_req && mcnt == mem_wait;
            dmem_rdata = dmem_ack ? rd_of(dmem_addr) : 32'hBAD0_BAD0;
            mcnt       = (dmem_req && !dmem_ack) ? mcnt + 1 : 0;
            cdb_grant  = reset && cdb_req && ccnt == cdb_wait;
            ccnt       = (cdb_req && !cdb_grant) ? ccnt + 1 : 0;
        end
    end

    task automatic check_head(input int k, input logic pop);
        exp_t e;
        if (sbq.size() == 0) begin
            chk("sb_underflow", sbq.size(), 1);
            return;
        end
        e = sbq[0];
        chk("sb_kind", k, e.kind);
        if (k == K_MIS) chk("mis_addr", ls_misalign_addr, e.addr);
        else if (k == K_MEM) begin
            chk("mem_we", dmem_we, e.we);
            chk("mem_addr", dmem_addr, e.addr);
            if (e.we) chk("mem_wdata", dmem_wdata, e.data);
        end else begin
            chk("cdb_tag", cdb_tag, e.tag);
            chk("cdb_data", cdb_data, e.data);
        end
        if (pop) e = sbq.pop_front();
    endtask

    // Monitor: compares every presented request against the scoreboard head.
    initial forever begin
        @(negedge clk);
        if (reset) begin
            chk("no_overlap", dmem_req && cdb_req, 0);
            if (!dmem_req) begin
                chk("we_low_outside_mem", dmem_we, 0);
                chk("wdata_zero_outside_mem", dmem_wdata, 0);
            end
            if (dmem_req || cdb_req) chk("done_low_busy", issuels_done, 0);
            if (dmem_req) dreq_cyc++;
            if (cdb_req) creq_cyc++;
            if (issuels_done) done_cyc++;
            if (ls_misalign) check_head(K_MIS, 1'b1);
            if (dmem_req) check_head(K_MEM, dmem_ack);
            if (cdb_req) check_head(K_CDB, cdb_grant);
        end
    end

    task automatic drive(input logic op, input logic [5:0] tag, input logic [31:0] addr, input logic [31:0] data);
        exp_t e;
        issuels_opcode = op;
        issuels_rttag  = tag;
        issuels_addr   = addr;
        issuels_data   = data;
        issuels_ready  = 1'b1;
        if (addr[1:0] != 2'b00) begin
            e = '{kind: K_MIS, we: 1'b0, tag: 6'd0, addr: addr, data: 32'd0};
            sbq.push_back(e);
        end else begin
            e = '{kind: K_MEM, we: op, tag: 6'd0, addr: addr, data: data};
            sbq.push_back(e);
            if (op) exp_nst++;
            else begin
                e = '{kind: K_CDB, we: 1'b0, tag: tag, addr: 32'd0, data: rd_of(addr)};
                sbq.push_back(e);
                exp_nld++;
            end
        end
    endtask

    task automatic send(input logic op, input logic [5:0] tag, input logic [31:0] addr, input logic [31:0] data, output int w);
        @(posedge clk);
        #1;
        drive(op, tag, addr, data);
        w = -1;
        for (int i = 0; i < 50 && w < 0; i++) begin
            @(negedge clk);
            if (issuels_done) w = i;
        end
        if (w < 0) chk("accept_timeout", w, 0);
        @(posedge clk);
        #1;
        issuels_ready = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        int n;
        n = 0;
        @(negedge clk);
        while ((dmem_req || cdb_req) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_settle"}, n < 2000, 1);
        @(negedge clk);
        #1;
        chk({nm, "_nload"}, ls_nload, exp_nld);
        chk({nm, "_nstore"}, ls_nstore, exp_nst);
        chk({nm, "_sb_drain"}, sbq.size(), 0);
    endtask

    task automatic burst(input int n);
        int got;
        got = 0;
        @(posedge clk);
        #1;
        drive(1'b1, 6'd0, 32'h1000, 32'h0);
        for (int c = 0; c < 4 * n + 20 && got < n; c++) begin
            @(negedge clk);
            if (issuels_done) begin
                got++;
                @(posedge clk);
                #1;
                if (got < n) drive(1'b1, 6'd0, 32'h1000 | 32'((got & 255) << 2), 32'(got));
                else issuels_ready = 1'b0;
            end
        end
        issuels_ready = 1'b0;
        chk("burst_count", got, n);
    endtask

    initial begin
        int   w, d0, c0, n0, k, n;
        logic got;
        int   acc[$];
        reset = 1'b0;
        issuels_ready = 1'b0;
        issuels_opcode = 1'b0;
        issuels_rttag = '0;
        issuels_addr = '0;
        issuels_data = '0;
        repeat (3) @(negedge clk);
        chk("rst_dmem_req", dmem_req, 0);
        chk("rst_dmem_we", dmem_we, 0);
        chk("rst_dmem_addr", dmem_addr, 0);
        chk("rst_dmem_wdata", dmem_wdata, 0);
        chk("rst_cdb_req", cdb_req, 0);
        chk("rst_cdb_tag", cdb_tag, 0);
        chk("rst_cdb_data", cdb_data, 0);
        chk("rst_misalign", ls_misalign, 0);
        chk("rst_misalign_addr", ls_misalign_addr, 0);
        chk("rst_nload", ls_nload, 0);
        chk("rst_nstore", ls_nstore, 0);
        chk("rst_done", issuels_done, 0);
        #1 reset = 1'b1;

        // Store, zero-wait memory.
        d0 = dreq_cyc; c0 = creq_cyc; n0 = done_cyc;
        send(1'b1, 6'd0, 32'h100, 32'hDEAD_BEEF, w);
        chk("sw_accept_wait", w, 0);
        wait_idle("sw");
        chk("sw_req_cycles", dreq_cyc - d0, 1);
        chk("sw_cdb_cycles", creq_cyc - c0, 0);
        chk("sw_done_cycles", done_cyc - n0, 1);

        // Load with 3 memory wait cycles and 2 grant wait cycles; queue stays ready.
        mem_wait = 3; cdb_wait = 2;
        d0 = dreq_cyc; c0 = creq_cyc; n0 = done_cyc;
        send(1'b0, 6'h2A, 32'h40, 32'h0, w);
        issuels_ready = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(cdb_req && cdb_grant) && n < 50);
        @(posedge clk);
        #1;
        issuels_ready = 1'b0;
        wait_idle("lw");
        chk("lw_req_cycles", dreq_cyc - d0, 4);
        chk("lw_cdb_cycles", creq_cyc - c0, 3);
        chk("lw_done_cycles", done_cyc - n0, 1);
        mem_wait = 0; cdb_wait = 0;

        // Misaligned store trapped, next store accepted on the following edge.
        send(1'b1, 6'd0, 32'h103, 32'h55, w);
        chk("mis_accept_wait", w, 0);
        d0 = dreq_cyc;
        drive(1'b1, 6'd0, 32'h200, 32'hCAFE_F00D);
        @(negedge clk);
        chk("mis_pulse", ls_misalign, 1);
        chk("mis_addr_reg", ls_misalign_addr, 32'h103);
        chk("mis_no_req", dmem_req, 0);
        chk("mis_next_done", issuels_done, 1);
        @(posedge clk);
        #1;
        issuels_ready = 1'b0;
        @(negedge clk);
        chk("mis_pulse_len", ls_misalign, 0);
        wait_idle("mis");
        chk("mis_req_cycles", dreq_cyc - d0, 1);

        // Back-to-back SW, LW, SW with ready held high.
        @(posedge clk);
        #1;
        k = 0;
        drive(1'b1, 6'd5, 32'h300, 32'hA000_0000);
        for (int c = 0; c < 30 && k < 3; c++) begin
            @(negedge clk);
            got = issuels_done;
            if (got) begin
                acc.push_back(c);
                k++;
            end
            @(posedge clk);
            #1;
            if (got && k < 3) drive(k % 2 == 0, 6'(k + 5), 32'h300 + 32'(4 * k), 32'hA000_0000 + 32'(k));
            if (got && k == 3) issuels_ready = 1'b0;
        end
        issuels_ready = 1'b0;
        chk("b2b_count", k, 3);
        if (k == 3) begin
            chk("b2b_second_at_T2", acc[1] - acc[0], 2);
            chk("b2b_third_at_T5", acc[2] - acc[0], 5);
        end
        wait_idle("b2b");

        // Reset while a load waits on memory.
        mem_wait = 1000;
        @(posedge clk);
        #1;
        drive(1'b0, 6'h11, 32'h80, 32'h0);
        @(negedge clk);
        chk("rr_done", issuels_done, 1);
        @(posedge clk);
        #1;
        issuels_ready = 1'b0;
        @(negedge clk);
        chk("rr_req_before", dmem_req, 1);
        #2 reset = 1'b0;
        #1;
        chk("rr_req_drop", dmem_req, 0);
        chk("rr_cdb_req", cdb_req, 0);
        chk("rr_addr_zero", dmem_addr, 0);
        chk("rr_nload", ls_nload, 0);
        chk("rr_nstore", ls_nstore, 0);
        sbq.delete();
        exp_nld = '0;
        exp_nst = '0;
        mem_wait = 0;
        repeat (2) @(posedge clk);
        #1;
        drive(1'b0, 6'h15, 32'h84, 32'h0);
        @(negedge clk);
        #1 reset = 1'b1;
        #1 chk("rr_first_done", issuels_done, 1);
        @(posedge clk);
        #1;
        issuels_ready = 1'b0;
        wait_idle("rr");

        // Store counter wrap.
        burst(65535);
        wait_idle("wrap_a");
        chk("wrap_ffff", ls_nstore, 16'hFFFF);
        burst(1);
        wait_idle("wrap_b");
        chk("wrap_zero", ls_nstore, 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
